mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  system clock, all state updates on its rising edge
- rst  in  1  asynchronous active-high reset
- address  in  16  CPU bus address
- databus  inout  8  shared tri-state CPU data bus
- RE  in  1  read strobe
- WE  in  1  write strobe
- rom_addr  out  15  cartridge ROM address, equal to address[14:0]
- rom_data  in  8  cartridge ROM data, combinational
- irq_pending  out  1  OR of (IE & IF), bits 4:0
- int_flags  out  5  current IF[4:0]

Function
REQ-003 The block SHALL be zero-wait: a read drives databus combinationally in the same cycle RE=1, so the initiator samples it at that cycle's clock edge. A write commits at the rising edge of the cycle WE=1.
REQ-004 databus SHALL be driven only when RE=1 and WE=0. Otherwise it SHALL be high-Z. If RE=1 and WE=1, the access SHALL be treated as a write.
REQ-005 Memory map, read data source:
- 0000-7FFF: rom_data
- C000-DFFF: 8 KiB WRAM
- E000-FDFF: WRAM echo at address-0x2000
- FF04: DIV
- FF05: TIMA
- FF06: TMA
- FF07: {5'b11111, TAC[2:0]}
- FF0F: {3'b111, IF[4:0]}
- FF80-FFFE: 127-byte HRAM
- FFFF: {3'b000, IE[4:0]}
- all other addresses: 0xFF
REQ-006 Writes to the ROM region and to unmapped addresses SHALL be ignored with no state change. Writes to the WRAM echo SHALL update the aliased WRAM byte.
REQ-007 Timer counter:
- A 16-bit sys_cnt SHALL increment by 1 every clk and wrap from 0xFFFF to 0x0000.
- DIV SHALL equal sys_cnt[15:8].
- Any write to FF04 SHALL clear sys_cnt to 0, regardless of the data written.
REQ-008 TIMA tick:
- tick_sig = TAC[2] AND sys_cnt[sel], where sel is 9, 3, 5 or 7 for TAC[1:0] = 00, 01, 10 or 11.
- TIMA SHALL increment on each cycle in which tick_sig falls from 1 to 0, using registered previous tick_sig.
- A falling edge caused by a DIV write or a TAC write SHALL also count.
REQ-009 TIMA overflow: when TIMA=0xFF and a tick occurs, TIMA SHALL load TMA and IF[2] SHALL be set in that same clock edge.
REQ-010 A CPU write to TIMA in the same cycle as a tick SHALL win: TIMA takes the written value, and no overflow or IF[2] set occurs.
REQ-011 A CPU write to TMA in the same cycle as an overflow reload SHALL reload the new TMA value.
REQ-012 A CPU write to IF in the same cycle as an overflow SHALL store data[4:0], with bit 2 forced to 1.
REQ-013 IE and IF SHALL store data[4:0] on write. Bits 7:5 SHALL be discarded.
REQ-014 irq_pending SHALL be combinational from the registered IE and IF values.
REQ-015 WRAM and HRAM contents SHALL hold their values across rst (no clear). A read of an unwritten location is undefined.

Reset
REQ-016 On rst, the following SHALL be cleared to 0: sys_cnt, the previous tick_sig, TIMA, TMA, TAC, IF and IE. This makes irq_pending=0, int_flags=0 and databus high-Z.
REQ-017 rst asserted mid-access SHALL abort the access, and no write SHALL commit at that edge.
REQ-018 After rst deasserts, sys_cnt SHALL count from 0, so DIV reads 0x01 at the 256th clock edge after deassertion.

Verification
REQ-019 Write 0x5A to C123, then read E123 -> databus=0x5A in the read cycle. Read C124 with RE=0 -> databus=Z.
REQ-020 Sequence:
- Write TAC=0x05, TMA=0xF0, TIMA=0xFE.
- After 32 clocks, TIMA=0xF0 and IF[2]=1.
- Then write IE=0x04 -> irq_pending=1 on the next cycle.
REQ-021 Sequence:
- TAC=0x04, sys_cnt=0x0200 (bit9=1).
- Write FF04 -> sys_cnt=0, and TIMA increments by 1 at that edge.
REQ-022 Write TIMA=0x10 in the exact cycle a tick occurs -> TIMA=0x10, not 0x11.
REQ-023 Read 0x8000, FEA0 and FF50 -> 0xFF. Write 0x12 to 0x2000 -> no state change, and a later read of 0x2000 returns rom_data.
REQ-024 Sequence:
- Write IF=0x1F, then assert rst mid-write of IE=0x1F.
- After reset, IF=0, IE=0, irq_pending=0, and an FF0F read returns 0xE0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: zero-wait CPU bus slave with ROM pass-through, WRAM/HRAM, DIV/TIMA timer and IE/IF.
module mem_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   inout  wire  [7:0]  databus,
   input  logic        RE,
   input  logic        WE,
   output logic [14:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        irq_pending,
   output logic [4:0]  int_flags
);
   logic [7:0]  wram [0:8191];
   logic [7:0]  hram [0:126];
   logic [15:0] sys_cnt, cnt_nxt;
   logic [7:0]  tima, tima_nxt, tma, tma_nxt, rd_data;
   logic [2:0]  tac, tac_nxt;
   logic [4:0]  if_q, if_nxt, ie_q, ie_nxt;
   logic        tick_q, tick_nxt, tick_fall, ovf;
   logic        is_wram, is_hram, wr_div, wr_tima, wr_tma, wr_tac, wr_if, wr_ie;

   assign is_wram = (address >= 16'hC000) && (address <= 16'hFDFF);
   assign is_hram = (address >= 16'hFF80) && (address != 16'hFFFF);
   assign wr_div  = WE && (address == 16'hFF04);
   assign wr_tima = WE && (address == 16'hFF05);
   assign wr_tma  = WE && (address == 16'hFF06);
   assign wr_tac  = WE && (address == 16'hFF07);
   assign wr_if   = WE && (address == 16'hFF0F);
   assign wr_ie   = WE && (address == 16'hFFFF);

   // Edge detection looks at the post-edge counter/TAC so DIV and TAC writes can cause a tick.
   always_comb begin
      cnt_nxt   = wr_div ? 16'h0000 : sys_cnt + 16'h0001;
      tac_nxt   = wr_tac ? databus[2:0] : tac;
      tick_nxt  = tac_nxt[2] & (tac_nxt[1:0] == 2'b00 ? cnt_nxt[9] :
                                tac_nxt[1:0] == 2'b01 ? cnt_nxt[3] :
                                tac_nxt[1:0] == 2'b10 ? cnt_nxt[5] : cnt_nxt[7]);
      tick_fall = tick_q & ~tick_nxt;
      ovf       = tick_fall && (tima == 8'hFF) && !wr_tima;
      tma_nxt   = wr_tma ? databus : tma;
      tima_nxt  = wr_tima ? databus : ovf ? tma_nxt : tima + {7'b0, tick_fall};
      if_nxt    = (wr_if ? databus[4:0] : if_q) | {2'b00, ovf, 2'b00};
      ie_nxt    = wr_ie ? databus[4:0] : ie_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_cnt <= 16'h0000;
         tick_q  <= 1'b0;
         tima    <= 8'h00;
         tma     <= 8'h00;
         tac     <= 3'b000;
         if_q    <= 5'b00000;
         ie_q    <= 5'b00000;
      end else begin
         sys_cnt <= cnt_nxt;
         tick_q  <= tick_nxt;
         tima    <= tima_nxt;
         tma     <= tma_nxt;
         tac     <= tac_nxt;
         if_q    <= if_nxt;
         ie_q    <= ie_nxt;
      end
   end

   // RAM contents survive reset; reset only blocks a write in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (!rst) begin
         if (WE && is_wram) wram[address[12:0]] <= databus;
         if (WE && is_hram) hram[address[6:0]] <= databus;
      end
   end

   always_comb begin
      rd_data = !address[15]           ? rom_data :
                is_wram                ? wram[address[12:0]] :
                is_hram                ? hram[address[6:0]] :
                address == 16'hFF04    ? sys_cnt[15:8] :
                address == 16'hFF05    ? tima :
                address == 16'hFF06    ? tma :
                address == 16'hFF07    ? {5'b11111, tac} :
                address == 16'hFF0F    ? {3'b111, if_q} :
                address == 16'hFFFF    ? {3'b000, ie_q} : 8'hFF;
   end

   assign databus     = (RE && !WE) ? rd_data : 8'hzz;
   assign rom_addr    = address[14:0];
   assign irq_pending = |(ie_q & if_q);
   assign int_flags   = if_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus timer/reset corner sequences for mem_responder.
module tb_mem_responder;
   logic        clk, rst, RE, WE, oe;
   logic [15:0] address;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data, drv;
   logic        irq_pending;
   logic [4:0]  int_flags;
   wire  [7:0]  databus;
   int          n_cmp = 0, n_bad = 0;

   typedef struct {
      string       nm;
      bit          w;
      logic [15:0] a;
      logic [7:0]  d;
   } vec_t;
   vec_t tbl [28];

   mem_responder dut (
      .clk(clk), .rst(rst), .address(address), .databus(databus), .RE(RE), .WE(WE),
      .rom_addr(rom_addr), .rom_data(rom_data), .irq_pending(irq_pending), .int_flags(int_flags)
   );

   assign databus  = oe ? drv : 8'hzz;
   assign rom_data = rom_addr[7:0] ^ 8'hA5;
   for (genvar g = 0; g < 8; g++) begin : g_pd
      pulldown (databus[g]);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      address = a; drv = d; oe = 1'b1; WE = 1'b1; RE = 1'b0;
      idle(1);
      WE = 1'b0; oe = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [15:0] a, input logic [7:0] exp);
      address = a; RE = 1'b1; WE = 1'b0;
      #1;
      chk(nm, {8'h00, databus}, {8'h00, exp});
      RE = 1'b0;
   endtask

   task automatic rst_mid_write(input logic [15:0] a, input logic [7:0] d);
      address = a; drv = d; oe = 1'b1; WE = 1'b1; RE = 1'b0;
      #1 rst = 1'b1;
      idle(1);
      WE = 1'b0; oe = 1'b0;
   endtask

   initial begin
      tbl = '{
         '{"w_c123", 1'b1, 16'hC123, 8'h5A}, '{"echo_e123", 1'b0, 16'hE123, 8'h5A},
         '{"w_e200", 1'b1, 16'hE200, 8'h77}, '{"wram_c200", 1'b0, 16'hC200, 8'h77},
         '{"w_fdff", 1'b1, 16'hFDFF, 8'h3E}, '{"wram_ddff", 1'b0, 16'hDDFF, 8'h3E},
         '{"w_ff80", 1'b1, 16'hFF80, 8'h11}, '{"w_fffe", 1'b1, 16'hFFFE, 8'h22},
         '{"hram_ff80", 1'b0, 16'hFF80, 8'h11}, '{"hram_fffe", 1'b0, 16'hFFFE, 8'h22},
         '{"w_rom2000", 1'b1, 16'h2000, 8'h12}, '{"rom_2000", 1'b0, 16'h2000, 8'hA5},
         '{"rom_7fff", 1'b0, 16'h7FFF, 8'h5A}, '{"unmap_8000", 1'b0, 16'h8000, 8'hFF},
         '{"unmap_fea0", 1'b0, 16'hFEA0, 8'hFF}, '{"w_fea0", 1'b1, 16'hFEA0, 8'h34},
         '{"unmap_fea0_w", 1'b0, 16'hFEA0, 8'hFF}, '{"unmap_ff50", 1'b0, 16'hFF50, 8'hFF},
         '{"w_tma", 1'b1, 16'hFF06, 8'h33}, '{"tma_rd", 1'b0, 16'hFF06, 8'h33},
         '{"w_tac_f8", 1'b1, 16'hFF07, 8'hF8}, '{"tac_f8", 1'b0, 16'hFF07, 8'hF8},
         '{"w_tac_03", 1'b1, 16'hFF07, 8'h03}, '{"tac_03", 1'b0, 16'hFF07, 8'hFB},
         '{"w_ie", 1'b1, 16'hFFFF, 8'hE3}, '{"ie_rd", 1'b0, 16'hFFFF, 8'h03},
         '{"w_if", 1'b1, 16'hFF0F, 8'hE5}, '{"if_rd", 1'b0, 16'hFF0F, 8'hE5}
      };
      rst = 1'b1; RE = 1'b0; WE = 1'b0; oe = 1'b0; drv = 8'h00; address = 16'h0000;
      idle(3);
      chk("rst_if", {11'b0, int_flags}, 16'h0000);
      chk("rst_irq", {15'b0, irq_pending}, 16'h0000);
      chk("rst_bus_z", {8'h00, databus}, 16'h0000);
      rd("rst_div", 16'hFF04, 8'h00);
      rd("rst_tima", 16'hFF05, 8'h00);
      rd("rst_tac", 16'hFF07, 8'hF8);
      rd("rst_if_rd", 16'hFF0F, 8'hE0);
      rst = 1'b0;
      idle(255);
      rd("div_255", 16'hFF04, 8'h00);
      idle(1);
      rd("div_256", 16'hFF04, 8'h01);

      for (int i = 0; i < $size(tbl); i++)
         if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
         else rd(tbl[i].nm, tbl[i].a, tbl[i].d);
      chk("tbl_int_flags", {11'b0, int_flags}, 16'h0005);
      chk("tbl_irq", {15'b0, irq_pending}, 16'h0001);
      address = 16'hABCD; #1;
      chk("rom_addr", {1'b0, rom_addr}, 16'h2BCD);
      wr(16'hFF0F, 8'h00);
      wr(16'hFFFF, 8'h00);
      chk("irq_clr", {15'b0, irq_pending}, 16'h0000);

      wr(16'hC124, 8'h3C);
      address = 16'hC124; RE = 1'b0; #1;
      chk("bus_z_re0", {8'h00, databus}, 16'h0000);
      rd("c124_re1", 16'hC124, 8'h3C);
      address = 16'hC300; drv = 8'h44; oe = 1'b1; RE = 1'b1; WE = 1'b1; #1;
      chk("rw_bus", {8'h00, databus}, 16'h0044);
      idle(1);
      RE = 1'b0; WE = 1'b0; oe = 1'b0;
      rd("rw_is_write", 16'hC300, 8'h44);

      wr(16'hFF07, 8'h05);
      wr(16'hFF06, 8'hF0);
      wr(16'hFF05, 8'hFE);
      idle(32);
      rd("ovf_tima", 16'hFF05, 8'hF0);
      chk("ovf_if2", {11'b0, int_flags}, 16'h0004);
      chk("ovf_irq_ie0", {15'b0, irq_pending}, 16'h0000);
      wr(16'hFFFF, 8'h04);
      chk("ovf_irq", {15'b0, irq_pending}, 16'h0001);

      wr(16'hFF0F, 8'h00);
      wr(16'hFFFF, 8'h00);
      wr(16'hFF04, 8'h00);
      wr(16'hFF05, 8'hFF);
      idle(14);
      wr(16'hFF05, 8'h10);
      rd("tima_wr_wins", 16'hFF05, 8'h10);
      chk("tima_wr_no_ovf", {11'b0, int_flags}, 16'h0000);
      idle(16);
      rd("tima_next_tick", 16'hFF05, 8'h11);
      wr(16'hFF05, 8'hFF);
      idle(14);
      wr(16'hFF06, 8'h77);
      rd("tma_wr_reload", 16'hFF05, 8'h77);
      chk("tma_wr_if2", {11'b0, int_flags}, 16'h0004);
      wr(16'hFF05, 8'hFF);
      idle(14);
      wr(16'hFF0F, 8'h09);
      rd("if_wr_ovf", 16'hFF0F, 8'hED);
      rd("if_wr_ovf_tima", 16'hFF05, 8'h77);

      wr(16'hFF07, 8'h04);
      wr(16'hFF04, 8'h00);
      idle(512);
      rd("div_0200", 16'hFF04, 8'h02);
      rd("tima_pre_div", 16'hFF05, 8'h77);
      wr(16'hFF04, 8'hA5);
      rd("div_wr_tick", 16'hFF05, 8'h78);
      rd("div_wr_clear", 16'hFF04, 8'h00);
      wr(16'hFF07, 8'h00);

      wr(16'hFF0F, 8'h1F);
      rst_mid_write(16'hFFFF, 8'h1F);
      chk("rst_mid_if", {11'b0, int_flags}, 16'h0000);
      chk("rst_mid_irq", {15'b0, irq_pending}, 16'h0000);
      rst = 1'b0;
      rd("rst_mid_if_rd", 16'hFF0F, 8'hE0);
      rd("rst_mid_ie_rd", 16'hFFFF, 8'h00);
      wr(16'hC400, 8'h66);
      rst_mid_write(16'hC400, 8'h99);
      rst = 1'b0;
      rd("wram_abort", 16'hC400, 8'h66);
      rd("wram_keep", 16'hC123, 8'h5A);
      rd("hram_keep", 16'hFF80, 8'h11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
